// File: rtl/pattern_serializer_tx.sv
// pattern_serializer_tx
// Serialises a W-bit pattern MSB first on line `a`, repeating it in_repeat
// extra times back to back, then pulses `done` for one cycle in IDLE.
// Optional feature: define PATTERN_SERIALIZER_TX_PARITY_EN to append one
// even-parity bit after every repetition of the pattern.
module pattern_serializer_tx #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_pattern,
  input  logic [CNT_W-1:0] in_repeat,
  output logic             a,
  output logic             a_valid,
  output logic             done
);

  localparam int BW = (W > 2) ? $clog2(W) : 1;

`ifdef PATTERN_SERIALIZER_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q;
  logic [W-1:0]     sh_q;
  logic [W-1:0]     pat_q;
  logic [CNT_W-1:0] rep_q;
  logic [BW-1:0]    bit_q;
  logic             done_q;
  logic             last_bit;

  assign last_bit = (bit_q == BW'(W - 1));

  // Control FSM, shift register and counters; done is set on the final
  // edge so it is high during the first IDLE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      pat_q   <= '0;
      rep_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_q    <= in_pattern;
            pat_q   <= in_pattern;
            rep_q   <= in_repeat;
            bit_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q  <= {sh_q[W-2:0], 1'b0};
          bit_q <= bit_q + BW'(1);
          if (last_bit) begin
            bit_q <= '0;
`ifdef PATTERN_SERIALIZER_TX_PARITY_EN
            state_q <= PARITY;
`else
            if (rep_q != '0) begin
              rep_q <= rep_q - CNT_W'(1);
              sh_q  <= pat_q;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
`endif
          end
        end
`ifdef PATTERN_SERIALIZER_TX_PARITY_EN
        PARITY: begin
          if (rep_q != '0) begin
            rep_q   <= rep_q - CNT_W'(1);
            sh_q    <= pat_q;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decoded purely from registered state; idle line level is 1.
  always_comb begin
    in_ready = (state_q == IDLE);
    done     = done_q;
    a        = 1'b1;
    a_valid  = 1'b0;
    case (state_q)
      SHIFT: begin
        a       = sh_q[W-1];
        a_valid = 1'b1;
      end
`ifdef PATTERN_SERIALIZER_TX_PARITY_EN
      PARITY: begin
        a       = ^pat_q;
        a_valid = 1'b1;
      end
`endif
      default: begin
        a       = 1'b1;
        a_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_serializer_tx.sv
// Testbench for pattern_serializer_tx: directed scenarios plus randomised
// requests compared against a bit-queue reference model.
module tb_pattern_serializer_tx;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_pattern;
  logic [CNT_W-1:0] in_repeat;
  logic             a;
  logic             a_valid;
  logic             done;

  int unsigned n_checks;
  int unsigned n_errors;
  bit          exp_bits[$];

  pattern_serializer_tx #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pattern (in_pattern),
    .in_repeat  (in_repeat),
    .a          (a),
    .a_valid    (a_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the full serial stream for one request.
  task automatic build_exp(input logic [W-1:0] pat, input int unsigned rep);
    exp_bits.delete();
    for (int unsigned r = 0; r <= rep; r++) begin
      for (int i = W - 1; i >= 0; i--) exp_bits.push_back(pat[i]);
`ifdef PATTERN_SERIALIZER_TX_PARITY_EN
      exp_bits.push_back(^pat);
`endif
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_req(input logic [W-1:0] pat, input int unsigned rep, input bit scramble);
    build_exp(pat, rep);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_pattern = pat;
    in_repeat  = CNT_W'(rep);
    @(negedge clk);
    if (scramble) begin
      in_pattern = ~pat;
      in_repeat  = CNT_W'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    for (int unsigned i = 0; i < exp_bits.size(); i++) begin
      chk("bit_valid", 32'(a_valid), 32'd1);
      chk("bit_value", 32'(a), 32'(exp_bits[i]));
      chk("busy_not_ready", 32'(in_ready), 32'd0);
      chk("no_early_done", 32'(done), 32'd0);
      if (scramble) begin
        in_pattern = W'($urandom);
        in_repeat  = CNT_W'($urandom);
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid_low", 32'(a_valid), 32'd0);
    chk("done_line_idle", 32'(a), 32'd1);
    chk("done_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic idle(input int unsigned n);
    in_valid   = 1'b0;
    in_pattern = W'($urandom);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_line", 32'(a), 32'd1);
      chk("idle_valid", 32'(a_valid), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_pattern = '0;
    in_repeat  = '0;
    #1;
    chk("rst_line", 32'(a), 32'd1);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Accept on the first edge after reset release.
    run_req(8'h5A, 0, 1'b0);
    idle(2);
    run_req(8'h81, 2, 1'b0);
    idle(1);
    // Inputs churn during transmission; next request accepted in done cycle.
    run_req(8'h01, 0, 1'b1);
    run_req(8'hC3, 1, 1'b0);
    idle(1);
    run_req(8'hA5, 15, 1'b0);
    idle(1);

    // Reset mid-transmission after three bits of 0xF0.
    build_exp(8'hF0, 0);
    in_valid   = 1'b1;
    in_pattern = 8'hF0;
    in_repeat  = '0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      chk("pre_rst_bit", 32'(a), 32'(exp_bits[i]));
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_line", 32'(a), 32'd1);
    chk("async_rst_valid", 32'(a_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    run_req(8'hF0, 0, 1'b0);
    idle(1);

    // Randomised requests with random gaps and input churn.
    for (int unsigned k = 0; k < 25; k++) begin
      run_req(W'($urandom), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
